// File: rtl/barcode_gen.sv
// Station-ID barcode transmitter: start bit (T low, T high) then 8 MSB-first bits in 2T cells, then a 2T gap.
// Optional BARCODE_GEN_ID_CHECK_EN refuses IDs with ID[7:6] != 0 and pulses reject.
module barcode_gen #(
  parameter int PERIOD_W = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                send,
  input  logic [7:0]          ID,
  input  logic [PERIOD_W-1:0] period,
  output logic                BC,
  output logic                busy,
  output logic                done,
  output logic                reject
);

  localparam int CW = PERIOD_W + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START_LO = 3'd1,
    START_HI = 3'd2,
    BIT_LO   = 3'd3,
    BIT_HI   = 3'd4,
    GAP      = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [PERIOD_W-1:0] t_q, t_new;
  logic [7:0]          sr;
  logic [3:0]          bit_cnt;
  logic [CW-1:0]       t_len, h_len, l0_len, cell_len, lo_cur, lo_next;
  logic                id_ok, accept, phase_end;
  logic                bc_nxt, busy_nxt, done_nxt;

  assign t_new    = (period < PERIOD_W'(4)) ? PERIOD_W'(4) : period;
  assign t_len    = {1'b0, t_q};
  assign h_len    = t_len >> 1;
  assign l0_len   = t_len + h_len;
  assign cell_len = t_len << 1;
  // The bit after the current one is already in sr[6] when BIT_HI reloads the counter.
  assign lo_cur   = sr[7] ? h_len : l0_len;
  assign lo_next  = sr[6] ? h_len : l0_len;

  assign phase_end = (cnt == CW'(1));

`ifdef BARCODE_GEN_ID_CHECK_EN
  assign id_ok = (ID[7:6] == 2'b00);
`else
  assign id_ok = 1'b1;
`endif

  assign accept = (state == IDLE) && send && id_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      t_q     <= '0;
      sr      <= '0;
      bit_cnt <= '0;
      BC      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      BC    <= bc_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      if (accept) begin
        t_q     <= t_new;
        sr      <= ID;
        bit_cnt <= '0;
      end else if (state == BIT_HI && phase_end) begin
        sr      <= {sr[6:0], 1'b0};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (state == IDLE) ? '0 : cnt - CW'(1);
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START_LO;
          cnt_nxt   = {1'b0, t_new};
        end
      end
      START_LO: begin
        if (phase_end) begin
          state_nxt = START_HI;
          cnt_nxt   = t_len;
        end
      end
      START_HI: begin
        if (phase_end) begin
          state_nxt = BIT_LO;
          cnt_nxt   = lo_cur;
        end
      end
      BIT_LO: begin
        if (phase_end) begin
          state_nxt = BIT_HI;
          cnt_nxt   = cell_len - lo_cur;
        end
      end
      BIT_HI: begin
        if (phase_end) begin
          if (bit_cnt == 4'd7) begin
            state_nxt = GAP;
            cnt_nxt   = cell_len;
          end else begin
            state_nxt = BIT_LO;
            cnt_nxt   = lo_next;
          end
        end
      end
      GAP: begin
        if (phase_end) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so BC/busy line up with state entry.
  always_comb begin
    bc_nxt   = !(state_nxt == START_LO || state_nxt == BIT_LO);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == GAP) && phase_end;
  end

`ifdef BARCODE_GEN_ID_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) reject <= 1'b0;
    else     reject <= (state == IDLE) && send && !id_ok;
  end
`else
  assign reject = 1'b0;
`endif

endmodule

// File: tb/tb_barcode_gen.sv
// Directed bench for barcode_gen: captures per-cycle outputs after each send and checks frame shape.
module tb_barcode_gen;

  localparam int NC = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        send;
  logic [7:0]  stim_id;
  logic [21:0] stim_period;
  logic        BC, busy, done, reject;

  int checks   = 0;
  int failures = 0;

  logic cap_bc   [0:NC-1];
  logic cap_busy [0:NC-1];
  logic cap_done [0:NC-1];
  logic cap_rej  [0:NC-1];

  barcode_gen #(.PERIOD_W(22)) dut (
    .clk    (clk),
    .rst    (rst),
    .send   (send),
    .ID     (stim_id),
    .period (stim_period),
    .BC     (BC),
    .busy   (busy),
    .done   (done),
    .reject (reject)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Cycle i of the capture is the i-th cycle after the edge that samples send.
  task automatic run_frame(input logic [7:0] id, input int per, input int ncap,
                           input int inj_a, input int inj_b,
                           input logic [7:0] id_b, input int per_b);
    @(negedge clk);
    stim_id     = id;
    stim_period = 22'(per);
    send        = 1'b1;
    for (int i = 0; i < NC; i++) begin
      cap_bc[i] = 1'b1; cap_busy[i] = 1'b0; cap_done[i] = 1'b0; cap_rej[i] = 1'b0;
    end
    for (int i = 1; i <= ncap; i++) begin
      @(negedge clk);
      cap_bc[i]   = BC;
      cap_busy[i] = busy;
      cap_done[i] = done;
      cap_rej[i]  = reject;
      send = 1'b0;
      if (i == inj_a) begin
        send = 1'b1; stim_id = 8'hFF; stim_period = 22'd20;
      end
      if (i == inj_b) begin
        send = 1'b1; stim_id = id_b; stim_period = 22'(per_b);
      end
    end
    send = 1'b0;
  endtask

  function automatic int low_run(input int p);
    int n = 0;
    while (p + n < NC && cap_bc[p+n] == 1'b0) n++;
    return n;
  endfunction

  function automatic int count_rej();
    int n = 0;
    for (int i = 1; i < NC; i++) if (cap_rej[i]) n++;
    return n;
  endfunction

  task automatic check_frame(input int base, input int t, input logic [7:0] id);
    int h  = t / 2;
    int p;
    int dn = -1;
    check("start_lo",  int'(cap_bc[base+1]), 0);
    check("start_len", low_run(base+1), t);
    check("start_hi",  int'(cap_bc[base+2*t]), 1);
    check("busy_on",   int'(cap_busy[base+1]), 1);
    for (int k = 0; k < 8; k++) begin
      p = base + 1 + 2*t*(k+1);
      check("bit_fall",   int'(cap_bc[p-1]), 1);
      check("bit_low",    low_run(p), id[7-k] ? h : t + h);
      check("bit_decode", int'(cap_bc[p+t]), int'(id[7-k]));
    end
    for (int j = base + 1; j < NC; j++)
      if (cap_done[j] && dn < 0) dn = j;
    check("done_at",  dn, base + 1 + 20*t);
    check("busy_end", int'(cap_busy[base+20*t]), 1);
    check("gap_hi",   int'(cap_bc[base+20*t]), 1);
    check("busy_off", int'(cap_busy[base+1+20*t]), 0);
  endtask

  initial begin
    int exp_lo[8] = '{12, 12, 4, 12, 4, 12, 4, 12};
    int nd, nz;

    rst = 1'b1; send = 1'b0; stim_id = 8'h00; stim_period = 22'd0;
    #2;
    check("rst_bc",     int'(BC), 1);
    check("rst_busy",   int'(busy), 0);
    check("rst_done",   int'(done), 0);
    check("rst_reject", int'(reject), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // ID 0x2A, T=8: hand-computed bit lows, done at N+161
    run_frame(8'h2A, 8, 170, 0, 0, 8'h00, 0);
    check_frame(0, 8, 8'h2A);
    for (int k = 0; k < 8; k++) check("lo_2a", low_run(1 + 16*(k+1)), exp_lo[k]);
    check("no_reject_2a", count_rej(), 0);

    // Odd T=9: L0=13, L1=4
    run_frame(8'h2A, 9, 185, 0, 0, 8'h00, 0);
    check_frame(0, 9, 8'h2A);
    check("odd_l0", low_run(1 + 18), 13);
    check("odd_l1", low_run(1 + 18*3), 4);

    // period=3 clamps to T=4, done at N+81
    run_frame(8'hFF, 3, 90, 0, 0, 8'h00, 0);
    check_frame(0, 4, 8'hFF);
    check("clamp_start", low_run(1), 4);

    // Mid-frame send ignored, then a send in the done cycle starts the next frame
    run_frame(8'h5C, 6, 260, 50, 121, 8'h81, 5);
    check_frame(0, 6, 8'h5C);
    check("b2b_bc",   int'(cap_bc[122]), 0);
    check("b2b_busy", int'(cap_busy[122]), 1);
    check_frame(121, 5, 8'h81);

    // Asynchronous reset mid-frame
    @(negedge clk);
    stim_id = 8'h2A; stim_period = 22'd8; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (39) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_bc",   int'(BC), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0; nz = 0;
    repeat (200) begin
      @(negedge clk);
      if (done) nd++;
      if (!BC || busy) nz++;
    end
    check("rst_no_done", nd, 0);
    check("rst_idle",    nz, 0);
    run_frame(8'h2A, 8, 170, 0, 0, 8'h00, 0);
    check_frame(0, 8, 8'h2A);

    // ID 0xC5: refused with the ID check, sent as 1,1,0,0,0,1,0,1 without it
    run_frame(8'hC5, 5, 110, 0, 0, 8'h00, 0);
`ifdef BARCODE_GEN_ID_CHECK_EN
    nz = 0; nd = 0;
    for (int i = 1; i <= 110; i++) begin
      if (!cap_bc[i]) nz++;
      if (cap_busy[i]) nd++;
    end
    check("rej_pulse", int'(cap_rej[1]), 1);
    check("rej_once",  count_rej(), 1);
    check("rej_bc",    nz, 0);
    check("rej_busy",  nd, 0);
`else
    check_frame(0, 5, 8'hC5);
    check("c5_no_reject", count_rej(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/barcode_gen.md
# barcode_gen

Serial barcode stream generator: the transmit end of the station-ID barcode protocol. It converts an 8-bit station ID into the self-timed BC waveform that the barcode receiver decodes. The waveform has a start bit that sets the time base, followed by 8 data bits sent MSB first. The block serves the bench stimulus and the station-emulator path, and plugs directly into the receiver's BC input.

## Interface
- PERIOD_W, 22: width of the time-base input; matches the receiver's 22-bit timing counters.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- send  in  1  request to transmit; sampled only in IDLE.
- ID  in  8  station ID to transmit; latched when `send` is accepted.
- period  in  PERIOD_W  time base T in clk cycles; latched when `send` is accepted.
- BC  out  1  serial barcode stream; idles high; registered.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at end of frame.
- reject  out  1  one-cycle pulse when a request is refused (only with the macro; tied 0 otherwise).

## Operation
- Reset values: BC=1, busy=0, done=0, reject=0, state IDLE, all counters 0.
- On accept, latch `ID` into an 8-bit shift register and latch T = max(period, 4).
- Derived lengths: H = T>>1, L1 = H, L0 = T+H, cell = 2T.
- States:
  - IDLE: BC=1. If `send`=1, go to START_LO.
  - START_LO: BC=0 for T cycles, then START_HI.
  - START_HI: BC=1 for T cycles, then BIT_LO.
  - BIT_LO: BC=0 for L1 cycles if the current MSB is 1, or L0 cycles if it is 0; then BIT_HI.
  - BIT_HI: BC=1 for (2T − low length) cycles. Then shift left and increment the 4-bit bit counter. After 8 bits go to GAP; otherwise go to BIT_LO.
  - GAP: BC=1 for 2T cycles, then IDLE with the done pulse.
- Decode rule: the receiver samples T cycles after each falling edge. It reads 1 (high) after a short low and 0 (low) after a long low.
- A single down-counter of width PERIOD_W+1 times every phase. It reloads on each state entry and advances the state when it reaches 1.
- `send` while busy is ignored; no queueing.
- `ID` and `period` changes mid-frame have no effect; the latched copies are used.
- Odd T: H is floored. Example: T=9 gives L1=4 and L0=13.

## Timing
- `send` sampled high in IDLE at edge N → BC=0 and busy=1 from cycle N+1.
- Frame length is exactly 20T cycles: start 2T, bits 16T, gap 2T.
- At cycle N+1+20T: done=1 and busy=0 for that one cycle, state IDLE. A `send` in that cycle is accepted (back-to-back frames).
- The first falling edge is at N+1. Each data-bit falling edge is at N+1+2T·(k+1), for k = 0..7.
- rst asserted mid-frame: BC=1, busy=0 and done=0 immediately (asynchronous). The frame is abandoned, with no done pulse.

## Configuration
- BARCODE_GEN_ID_CHECK_EN defined:
  - A `send` with ID[7:6] ≠ 2'b00 is refused.
  - reject pulses for 1 cycle at N+1, BC stays high, busy stays 0.
  - Valid IDs behave as normal.
- Undefined: every ID is transmitted as-is, and reject is constant 0.

## Test plan
- ID=0x2A, period=8, send at N:
  - BC low from N+1 to N+8, high from N+9 to N+16.
  - Bit lows are 12,12,4,12,4,12,4,12 cycles, each in a 16-cycle cell.
  - done pulse and busy=0 at N+161.
- Loopback into the barcode receiver, ID=0x15, period=1000 → receiver ID=0x15 with ID_vld=1 after frame end; `clr_ID_vld` then clears it.
- period=3, ID=0xFF → T clamped to 4: start low 4 cycles, each bit low 2 and high 6, done at N+81.
- send pulsed again at N+50 during a frame → ignored, frame unchanged. Then send in the done cycle → a new frame starts the next cycle.
- rst asserted at N+40 → BC=1 and busy=0 in the same cycle, no done. After release, a send transmits a full clean frame.
- With BARCODE_GEN_ID_CHECK_EN, ID=0xC5 → reject at N+1, BC stays 1, busy stays 0. Without the macro, the same stimulus produces a full frame with bits 1,1,0,0,0,1,0,1.
